// File: rtl/operand_bypass_unit.sv
// ID-stage operand generator: selects operands, bypasses pending GPR writes,
// detects load-use hazards and registers the result into a valid/ready slot.
module operand_bypass_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned FWD_CHANNELS   = 3,
  parameter int unsigned LINK_OFFSET    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [ADDR_WIDTH-1:0]                  in_addr,
  input  logic [1:0]                             src1_mode,
  input  logic [1:0]                             src2_mode,
  input  logic [15:0]                            imm,
  input  logic [REG_ADDR_WIDTH-1:0]              rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0]              rt_addr,
  input  logic [DATA_WIDTH-1:0]                  reg_data_1,
  input  logic [DATA_WIDTH-1:0]                  reg_data_2,
  input  logic [DATA_WIDTH-1:0]                  cp_read_data,
  input  logic [FWD_CHANNELS-1:0]                fwd_valid,
  input  logic [FWD_CHANNELS-1:0]                fwd_load,
  input  logic [FWD_CHANNELS*REG_ADDR_WIDTH-1:0] fwd_reg_addr,
  input  logic [FWD_CHANNELS*DATA_WIDTH-1:0]     fwd_data,
  input  logic                                   flush,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH-1:0]                  operand_1,
  output logic [DATA_WIDTH-1:0]                  operand_2,
  output logic                                   hazard_stall,
  output logic [15:0]                            stall_cycles
);

  localparam logic [1:0] Src1Reg  = 2'd0;
  localparam logic [1:0] Src1Link = 2'd1;
  localparam logic [1:0] Src1Cp0  = 2'd2;
  localparam logic [1:0] Src1Zero = 2'd3;
  localparam logic [1:0] Src2Reg  = 2'd0;
  localparam logic [1:0] Src2Sext = 2'd1;
  localparam logic [1:0] Src2Zext = 2'd2;
  localparam logic [1:0] Src2Hi   = 2'd3;

  logic [ADDR_WIDTH-1:0] link_sum;
  logic [DATA_WIDTH-1:0] link_data;
  logic [DATA_WIDTH-1:0] sext_data;
  logic [DATA_WIDTH-1:0] zext_data;
  logic [DATA_WIDTH-1:0] hi_data;
  logic [DATA_WIDTH:0]   rs_res;
  logic [DATA_WIDTH:0]   rt_res;
  logic [DATA_WIDTH-1:0] op1_next;
  logic [DATA_WIDTH-1:0] op2_next;
  logic                  haz1;
  logic                  haz2;
  logic                  capture;

  assign link_sum  = in_addr + ADDR_WIDTH'(LINK_OFFSET);
  assign link_data = DATA_WIDTH'(link_sum);
  assign sext_data = DATA_WIDTH'($signed(imm));
  assign zext_data = DATA_WIDTH'(imm);
  assign hi_data   = DATA_WIDTH'({imm, 16'h0000});

  // Returns {hazard, data}; the first matching channel decides, even if it is a load.
  function automatic logic [DATA_WIDTH:0] resolve(input logic [REG_ADDR_WIDTH-1:0] idx,
                                                  input logic [DATA_WIDTH-1:0]     rf);
    logic                found;
    logic [DATA_WIDTH:0] res;
    found = 1'b0;
    res   = {1'b0, rf};
    if (idx != '0) begin
      for (int unsigned i = 0; i < FWD_CHANNELS; i++) begin
        if (!found && fwd_valid[i] &&
            fwd_reg_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == idx) begin
          found = 1'b1;
          res   = fwd_load[i] ? {1'b1, rf} : {1'b0, fwd_data[i*DATA_WIDTH +: DATA_WIDTH]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    rs_res   = resolve(rs_addr, reg_data_1);
    rt_res   = resolve(rt_addr, reg_data_2);
    op1_next = '0;
    op2_next = '0;
    haz1     = 1'b0;
    haz2     = 1'b0;
    case (src1_mode)
      Src1Reg: begin
        op1_next = rs_res[DATA_WIDTH-1:0];
        haz1     = rs_res[DATA_WIDTH];
      end
      Src1Link: op1_next = link_data;
      Src1Cp0:  op1_next = cp_read_data;
      Src1Zero: op1_next = '0;
      default:  op1_next = '0;
    endcase
    case (src2_mode)
      Src2Reg: begin
        op2_next = rt_res[DATA_WIDTH-1:0];
        haz2     = rt_res[DATA_WIDTH];
      end
      Src2Sext: op2_next = sext_data;
      Src2Zext: op2_next = zext_data;
      Src2Hi:   op2_next = hi_data;
      default:  op2_next = '0;
    endcase
  end

  assign hazard_stall = in_valid & (haz1 | haz2);
  assign in_ready     = (~out_valid | out_ready) & ~hazard_stall & ~flush;
  assign capture      = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      operand_1    <= '0;
      operand_2    <= '0;
      stall_cycles <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid <= 1'b1;
        operand_1 <= op1_next;
        operand_2 <= op2_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (hazard_stall && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Scoreboard bench for operand_bypass_unit: expected operand pairs are queued at
// each accepted handshake and compared when the slot drains.
module tb_operand_bypass_unit;

  localparam logic [1:0] M1Reg = 2'd0, M1Link = 2'd1, M1Cp0 = 2'd2, M1Zero = 2'd3;
  localparam logic [1:0] M2Reg = 2'd0, M2Sext = 2'd1, M2Zext = 2'd2, M2Hi = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [1:0]  src1_mode;
  logic [1:0]  src2_mode;
  logic [15:0] imm;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] reg_data_1;
  logic [31:0] reg_data_2;
  logic [31:0] cp_read_data;
  logic [2:0]  fwd_valid;
  logic [2:0]  fwd_load;
  logic [14:0] fwd_reg_addr;
  logic [95:0] fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        hazard_stall;
  logic [15:0] stall_cycles;

  logic [31:0] exp_op1;
  logic [31:0] exp_op2;
  logic [63:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  operand_bypass_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .src1_mode(src1_mode), .src2_mode(src2_mode), .imm(imm), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .reg_data_1(reg_data_1), .reg_data_2(reg_data_2),
    .cp_read_data(cp_read_data), .fwd_valid(fwd_valid), .fwd_load(fwd_load),
    .fwd_reg_addr(fwd_reg_addr), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .operand_1(operand_1),
    .operand_2(operand_2), .hazard_stall(hazard_stall), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Scoreboard: pop/compare on a draining handshake, push on an accepted one.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (flush) begin
        if (out_valid && sb.size() > 0) e = sb.pop_front();
      end else if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got %h_%h, required no output", operand_1, operand_2);
        end else begin
          e = sb.pop_front();
          if ({operand_1, operand_2} !== e) begin
            n_err++;
            $display("FAIL sb_data: got %h_%h, required %h_%h",
                     operand_1, operand_2, e[63:32], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back({exp_op1, exp_op2});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_addr = '0; src1_mode = M1Zero; src2_mode = M2Zext; imm = '0;
    rs_addr = '0; rt_addr = '0; reg_data_1 = '0; reg_data_2 = '0; cp_read_data = '0;
    fwd_valid = '0; fwd_load = '0; fwd_reg_addr = '0; fwd_data = '0; flush = 0;
    out_ready = 1; exp_op1 = '0; exp_op2 = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    cyc(); cyc();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    n_cmp++; if ({operand_1, operand_2} !== 64'h0) begin n_err++; $display("FAIL rst_ops: got %h_%h, required 0", operand_1, operand_2); end
    n_cmp++; if (stall_cycles !== 16'h0) begin n_err++; $display("FAIL rst_stall: got %h, required 0", stall_cycles); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_link_hi();
    cyc();
    in_valid = 1; src1_mode = M1Link; in_addr = 32'h0040_0010; src2_mode = M2Hi; imm = 16'h1234;
    exp_op1 = 32'h0040_0018; exp_op2 = 32'h1234_0000;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL link_ready: got %b, required 1", in_ready); end
    cyc();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL link_valid: got %b, required 1", out_valid); end
    n_cmp++; if (operand_1 !== 32'h0040_0018) begin n_err++; $display("FAIL link_op1: got %h, required 00400018", operand_1); end
    n_cmp++; if (operand_2 !== 32'h1234_0000) begin n_err++; $display("FAIL link_op2: got %h, required 12340000", operand_2); end
  endtask

  task automatic test_modes();
    logic [1:0]  m1[4] = '{M1Zero, M1Cp0, M1Reg, M1Link};
    logic [1:0]  m2[4] = '{M2Sext, M2Zext, M2Reg, M2Hi};
    logic [15:0] im[4] = '{16'h8001, 16'h8001, 16'h0000, 16'hFFFF};
    logic [31:0] ad[4] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC};
    logic [31:0] e1[4] = '{32'h0, 32'h1357_9BDF, 32'h1111_1111, 32'h0000_0004};
    logic [31:0] e2[4] = '{32'hFFFF_8001, 32'h0000_8001, 32'h2222_2222, 32'hFFFF_0000};
    for (int i = 0; i < 4; i++) begin
      cyc();
      in_valid = 1; src1_mode = m1[i]; src2_mode = m2[i]; imm = im[i]; in_addr = ad[i];
      cp_read_data = 32'h1357_9BDF; rs_addr = 5'd3; rt_addr = 5'd4;
      reg_data_1 = 32'h1111_1111; reg_data_2 = 32'h2222_2222;
      exp_op1 = e1[i]; exp_op2 = e2[i];
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL modes_ready[%0d]: got %b, required 1", i, in_ready); end
    end
    cyc();
    idle();
    @(negedge clk);
    n_cmp++; if (operand_1 !== 32'h4 || out_valid !== 1'b1) begin n_err++; $display("FAIL modes_last: got %b/%h, required 1/00000004", out_valid, operand_1); end
  endtask

  task automatic test_bypass();
    logic [4:0]  b_rs[3] = '{5'd5, 5'd0, 5'd5};
    logic [4:0]  b_rt[3] = '{5'd9, 5'd9, 5'd5};
    logic [2:0]  b_fv[3] = '{3'b111, 3'b111, 3'b100};
    logic [14:0] b_fa[3] = '{{5'd5, 5'd9, 5'd5}, {5'd0, 5'd0, 5'd0}, {5'd5, 5'd5, 5'd5}};
    logic [31:0] b_r1[3] = '{32'h5555_5555, 32'h0, 32'h5555_5555};
    logic [31:0] b_e1[3] = '{32'hAAAA_0000, 32'h0, 32'hBBBB_0000};
    logic [31:0] b_e2[3] = '{32'hCCCC_0000, 32'h6666_6666, 32'hBBBB_0000};
    for (int i = 0; i < 3; i++) begin
      cyc();
      in_valid = 1; src1_mode = M1Reg; src2_mode = M2Reg;
      rs_addr = b_rs[i]; rt_addr = b_rt[i]; reg_data_1 = b_r1[i]; reg_data_2 = 32'h6666_6666;
      fwd_valid = b_fv[i]; fwd_load = '0; fwd_reg_addr = b_fa[i];
      fwd_data = {32'hBBBB_0000, 32'hCCCC_0000, 32'hAAAA_0000};
      exp_op1 = b_e1[i]; exp_op2 = b_e2[i];
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL byp_ready[%0d]: got %b, required 1", i, in_ready); end
      cyc();
      in_valid = 0;
      @(negedge clk);
      n_cmp++; if (operand_1 !== b_e1[i]) begin n_err++; $display("FAIL byp_op1[%0d]: got %h, required %h", i, operand_1, b_e1[i]); end
    end
    idle();
  endtask

  task automatic test_load_use();
    cyc();
    in_valid = 1; src1_mode = M1Zero; src2_mode = M2Reg; rt_addr = 5'd7; reg_data_2 = 32'h7;
    fwd_valid = 3'b110; fwd_load = 3'b010; fwd_reg_addr = {5'd7, 5'd7, 5'd0};
    fwd_data = {32'h0000_0001, 32'h0BAD_0BAD, 32'h0};
    exp_op1 = 32'h0; exp_op2 = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (hazard_stall !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL lu_stall[%0d]: got %b/%b, required 1/0", i, hazard_stall, in_ready); end
      cyc();
    end
    fwd_load = 3'b000; fwd_data = {32'h0000_0001, 32'hDEAD_BEEF, 32'h0};
    @(negedge clk);
    n_cmp++; if (stall_cycles !== 16'd3) begin n_err++; $display("FAIL lu_count: got %0d, required 3", stall_cycles); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_release: got %b, required 1", in_ready); end
    cyc();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (operand_2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lu_op2: got %h, required deadbeef", operand_2); end
    // Non-REG modes must ignore a matching in-flight load.
    cyc();
    in_valid = 1; src1_mode = M1Zero; src2_mode = M2Sext; imm = 16'h7FFF; rs_addr = 5'd7;
    fwd_load = 3'b010; exp_op1 = 32'h0; exp_op2 = 32'h0000_7FFF;
    @(negedge clk);
    n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL lu_nonreg: got %b, required 0", hazard_stall); end
    cyc();
    idle();
  endtask

  task automatic test_back_to_back();
    cyc();
    out_ready = 0; in_valid = 1; src1_mode = M1Zero; src2_mode = M2Zext; imm = 16'h0A0A;
    exp_op1 = 32'h0; exp_op2 = 32'h0000_0A0A;
    cyc();
    src1_mode = M1Cp0; cp_read_data = 32'hB0B0_B0B0; imm = 16'h0B0B;
    exp_op1 = 32'hB0B0_B0B0; exp_op2 = 32'h0000_0B0B;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b, required 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || operand_2 !== 32'h0A0A) begin n_err++; $display("FAIL bp_hold[%0d]: got %b/%h, required 1/00000a0a", i, out_valid, operand_2); end
      cyc();
    end
    out_ready = 1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume: got %b, required 1", in_ready); end
    cyc();
    src1_mode = M1Zero; imm = 16'h0C0C; exp_op1 = 32'h0; exp_op2 = 32'h0000_0C0C;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || operand_2 !== 32'h0B0B) begin n_err++; $display("FAIL bp_b2b: got %b/%h, required 1/00000b0b", out_valid, operand_2); end
    cyc();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || operand_2 !== 32'h0C0C) begin n_err++; $display("FAIL bp_c: got %b/%h, required 1/00000c0c", out_valid, operand_2); end
    cyc();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b, required 0", out_valid); end
    idle();
  endtask

  task automatic test_flush();
    cyc();
    out_ready = 0; in_valid = 1; imm = 16'h1111; exp_op2 = 32'h1111;
    cyc();
    imm = 16'h2222; exp_op2 = 32'h2222; out_ready = 1; flush = 1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL fl_pre: got %b/%b, required 0/1", in_ready, out_valid); end
    cyc();
    flush = 0; in_valid = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_kill: got %b, required 0", out_valid); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    cyc();
    out_ready = 0; in_valid = 1; imm = 16'h3333; exp_op2 = 32'h3333;
    cyc();
    src2_mode = M2Reg; rt_addr = 5'd7; fwd_valid = 3'b010; fwd_load = 3'b010;
    fwd_reg_addr = {5'd0, 5'd7, 5'd0};
    cyc(); cyc();
    #2;
    rst = 1;
    sb.delete();
    #1;
    n_cmp++; if (out_valid !== 1'b0 || stall_cycles !== 16'h0) begin n_err++; $display("FAIL mid_rst: got %b/%0d, required 0/0", out_valid, stall_cycles); end
    n_cmp++; if (operand_2 !== 32'h0) begin n_err++; $display("FAIL mid_rst_op: got %h, required 0", operand_2); end
    idle();
    @(posedge clk); #1 rst = 0;
    cyc();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || stall_cycles !== 16'h0) begin n_err++; $display("FAIL post_rst: got %b/%0d, required 0/0", out_valid, stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_link_hi();
    test_modes();
    test_bypass();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    cyc();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_bypass_unit.md
Name: operand_bypass_unit

Overview:
- Parametrised, pipelined successor to the ID-stage operand generator.
- Selects operand 1 and operand 2 from register file, link address, CP0 read data or the immediate forms. Operand 1 modes: REG, LINK, CP0, ZERO. Operand 2 modes: REG, SEXT, ZEXT, HI.
- Resolves RAW hazards through N prioritised bypass channels and detects load-use hazards.
- Registers the result into an ID/EX output slot with a valid/ready handshake. Sits between decode and the EX stage.

Parameters:
- DATA_WIDTH, 32, operand/data width.
- ADDR_WIDTH, 32, PC width.
- REG_ADDR_WIDTH, 5, GPR index width.
- FWD_CHANNELS, 3, number of bypass sources; index 0 = youngest stage, highest priority.
- LINK_OFFSET, 8, added to PC for link address.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  unit accepts the instruction this cycle.
- in_addr  in  ADDR_WIDTH  instruction PC.
- src1_mode  in  2  0 REG, 1 LINK, 2 CP0, 3 ZERO.
- src2_mode  in  2  0 REG(rt), 1 SEXT imm, 2 ZEXT imm, 3 HI imm (imm<<16).
- imm  in  16  instruction immediate.
- rs_addr, rt_addr  in  REG_ADDR_WIDTH each  source register indices.
- reg_data_1, reg_data_2  in  DATA_WIDTH each  register file read data.
- cp_read_data  in  DATA_WIDTH  CP0 read data.
- fwd_valid  in  FWD_CHANNELS  channel carries a pending GPR write.
- fwd_load  in  FWD_CHANNELS  channel's data not yet available (load in flight).
- fwd_reg_addr  in  FWD_CHANNELS*REG_ADDR_WIDTH  destination index per channel, packed, channel 0 in LSBs.
- fwd_data  in  FWD_CHANNELS*DATA_WIDTH  write data per channel, packed.
- flush  in  1  kill the output slot and any capture this cycle.
- out_valid  out  1  output slot holds an instruction.
- out_ready  in  1  EX stage consumes the slot.
- operand_1, operand_2  out  DATA_WIDTH each  registered operands.
- hazard_stall  out  1  combinational; load-use hazard is blocking acceptance.
- stall_cycles  out  16  saturating count of hazard_stall cycles.

Behaviour:
- Reset (async, rst=1): out_valid=0, operand_1=0, operand_2=0, stall_cycles=0. in_ready and hazard_stall follow their combinational equations with out_valid=0.
- Operand sources:
  - LINK = in_addr + LINK_OFFSET, modulo 2^ADDR_WIDTH, zero-extended or truncated to DATA_WIDTH.
  - SEXT = sign-extend imm. ZEXT = zero-extend imm. HI = {imm, 16'b0}.
- Bypass, applied per REG-mode operand:
  - Source index 0 never matches a channel; register data is used (GPR0 reads 0).
  - Otherwise the lowest-index channel with fwd_valid=1 and matching fwd_reg_addr wins.
  - Winner with fwd_load=0: its fwd_data replaces the register read.
  - Winner with fwd_load=1: hazard. A matching lower-priority channel does not resolve it.
  - No match: register data used.
  - Non-REG modes ignore the bypass network and never raise a hazard.
- hazard_stall = in_valid & (hazard on operand 1 | hazard on operand 2).
- in_ready = (~out_valid | out_ready) & ~hazard_stall & ~flush.
- Capture: when in_valid & in_ready at a clk edge, operand_1/operand_2 load the resolved values and out_valid=1. Latency is 1 cycle.
- Slot state per clk edge, in priority order:
  - flush=1 → out_valid=0; operands hold (don't-care).
  - capture → out_valid=1, operands updated.
  - out_valid & out_ready → out_valid=0.
  - otherwise hold; operands stable while out_valid & ~out_ready.
- Simultaneous drain and capture: slot is refilled; out_valid stays 1 (full throughput, no bubble).
- stall_cycles increments by 1 on each edge with hazard_stall=1, saturating at 16'hFFFF. It is cleared only by rst.
- Reset mid-operation discards the slot immediately. in_valid is ignored while rst=1.
- Inputs are sampled only when captured; the decode stage holds in_valid and data stable until accepted.

Test Plan:
- Reset then src1_mode=LINK, in_addr=0x00400010, src2_mode=HI, imm=0x1234, out_ready=1 → next cycle out_valid=1, operand_1=0x00400018, operand_2=0x12340000.
- rs=5, channels 0 and 2 both valid with addr 5, fwd_data 0xAAAA0000 / 0xBBBB0000, load=0 → operand_1=0xAAAA0000. Repeat with rs=0 → operand_1 = reg_data_1 value 0.
- rt=7, channel 1 valid, addr 7, load=1 for 3 cycles then 0 with data 0xDEADBEEF → hazard_stall=1 and in_ready=0 for 3 cycles; stall_cycles=3; then operand_2=0xDEADBEEF captured.
- out_ready=0 with slot full and new in_valid → in_ready=0, operands unchanged. Raise out_ready with in_valid held → back-to-back transfers with no bubble.
- flush=1 while out_valid=1 and in_valid=1 → next cycle out_valid=0, nothing captured.
- Assert rst asynchronously mid-stall → out_valid=0 and stall_cycles=0 before the next clk edge.
